// File: rtl/fxp_pkg.sv
// Shared fixed-point format constants and FSM state encodings for the
// multiplier arbiter slice.
package fxp_pkg;
    localparam int FXP_BITSIZE   = 20;
    localparam int FXP_INT_BITS  = 4;
    localparam int FXP_FRAC_BITS = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/fixed_point_multiply.sv
// Combinational signed fixed-point multiply (sign + int + FXP_FRAC_BITS frac).
// Result is floor-scaled back to the operand format and saturated.
module fixed_point_multiply import fxp_pkg::*; #(
    parameter int BITSIZE = FXP_BITSIZE
) (
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    output logic [BITSIZE-1:0] c
);
    logic signed [2*BITSIZE-1:0] a_x, b_x, prod, scaled;
    logic                        overflow;

    assign a_x    = {{BITSIZE{a[BITSIZE-1]}}, a};
    assign b_x    = {{BITSIZE{b[BITSIZE-1]}}, b};
    assign prod   = a_x * b_x;
    assign scaled = prod >>> FXP_FRAC_BITS;

    // Fits only when every bit above the result sign bit matches it.
    assign overflow = (|scaled[2*BITSIZE-1:BITSIZE-1]) & ~(&scaled[2*BITSIZE-1:BITSIZE-1]);

    always_comb begin
        c = scaled[BITSIZE-1:0];
        if (overflow)
            c = scaled[2*BITSIZE-1] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first asserted request at or after ptr wins.
// gnt is one-hot and only driven when en is high; any reports a pending request.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any
);
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        idx     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        any = found;
        gnt = '0;
        if (en && found)
            gnt[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/fixed_point_mul_arbiter.sv
// Shares one fixed_point_multiply between NUM_REQ requesters with round-robin
// arbitration and a single id-tagged, registered response channel.
module fixed_point_mul_arbiter import fxp_pkg::*; #(
    parameter int BITSIZE = FXP_BITSIZE,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BITSIZE-1:0] req_a,
    input  logic [NUM_REQ*BITSIZE-1:0] req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    output logic [BITSIZE-1:0]         res_data,
    output logic [ID_W-1:0]            res_id,
    input  logic                       res_ready,
    output logic                       busy
);
    logic [1:0]                      state, next_state;
    logic [ID_W-1:0]                 rr_ptr, op_id, gnt_idx;
    logic [BITSIZE-1:0]              op_a, op_b, product;
    logic [NUM_REQ-1:0][BITSIZE-1:0] lane_a, lane_b;
    logic                            arb_en, any_req, grant;

    assign lane_a = req_a;
    assign lane_b = req_b;
    assign grant  = arb_en & any_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req(req_valid), .ptr(rr_ptr), .en(arb_en),
        .gnt(req_ready), .gnt_idx(gnt_idx), .any(any_req)
    );

    fixed_point_multiply #(.BITSIZE(BITSIZE)) u_mul (
        .a(op_a), .b(op_b), .c(product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: next_state = any_req ? ST_MUL : ST_IDLE;
            ST_MUL:  next_state = ST_HOLD;
            ST_HOLD: next_state = !res_ready ? ST_HOLD : (any_req ? ST_MUL : ST_IDLE);
            default: next_state = ST_IDLE;
        endcase
    end

    // Grants are gated by rst_n so req_ready reads 0 while reset is held.
    always_comb begin
        arb_en = 1'b0;
        busy   = (state != ST_IDLE);
        case (state)
            ST_IDLE: arb_en = rst_n;
            ST_HOLD: arb_en = rst_n & res_ready;
            default: arb_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else begin
            if (grant) begin
                op_a   <= lane_a[gnt_idx];
                op_b   <= lane_b[gnt_idx];
                op_id  <= gnt_idx;
                rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (state == ST_MUL) begin
                res_data  <= product;
                res_id    <= op_id;
                res_valid <= 1'b1;
            end else if (state != ST_HOLD || res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_mul_arbiter.sv
// Directed bench for fixed_point_mul_arbiter: reset, single op, round robin,
// backpressure, signed/saturating products and request withdrawal.
module tb_fixed_point_mul_arbiter;
    localparam int BITSIZE = 20;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ*BITSIZE-1:0] req_a = '0;
    logic [NUM_REQ*BITSIZE-1:0] req_b = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       res_valid;
    logic [BITSIZE-1:0]         res_data;
    logic [ID_W-1:0]            res_id;
    logic                       res_ready = 1'b0;
    logic                       busy;

    int compared   = 0;
    int mismatched = 0;

    fixed_point_mul_arbiter #(.BITSIZE(BITSIZE), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] b);
        req_a[i*BITSIZE +: BITSIZE] = a;
        req_b[i*BITSIZE +: BITSIZE] = b;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL por_res_valid: got %b want 0", res_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL por_busy: got %b want 0", busy); end
        compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL por_req_ready: got %b want 0000", req_ready); end
        compared++; if (res_data !== 20'h00000) begin mismatched++; $display("FAIL por_res_data: got %h want 00000", res_data); end
        compared++; if (res_id !== 2'd0) begin mismatched++; $display("FAIL por_res_id: got %0d want 0", res_id); end
        step();
        rst_n = 1'b1;
        step();
        // Park a result in HOLD, then reset underneath it.
        set_lane(2, 20'h08000, 20'h08000);
        req_valid = 4'b0100;
        res_ready = 1'b0;
        step();
        req_valid = 4'b0000;
        step();
        compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL hold_before_reset: res_valid got %b want 1", res_valid); end
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_res_valid: got %b want 0", res_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", busy); end
        compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL midrst_req_ready: got %b want 0000", req_ready); end
        step();
        rst_n = 1'b1;
        #1;
        compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL post_rst_grant: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        step();
        step();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL post_rst_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [BITSIZE-1:0] exp_data [4];
        logic [3:0]         want;
        exp_data[0] = 20'h18000;  // 1.0 * 3.0
        exp_data[1] = 20'hF0000;  // 2.0 * -1.0
        exp_data[2] = 20'h02000;  // 0.5 * 0.5
        exp_data[3] = 20'hFFFF8;  // -1 lsb * 8.0
        set_lane(0, 20'h08000, 20'h18000);
        set_lane(1, 20'h10000, 20'hF8000);
        set_lane(2, 20'h04000, 20'h04000);
        set_lane(3, 20'hFFFFF, 20'h40000);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL rr_first_grant: got %b want 0001", req_ready); end
        step();
        compared++; if (res_valid !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL rr_mul_state: valid %b busy %b want 0 1", res_valid, busy); end
        for (int k = 0; k < 8; k++) begin
            step();
            want = 4'b0001 << ((k + 1) % 4);
            compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL rr_valid[%0d]: got %b want 1", k, res_valid); end
            compared++; if (res_id !== ID_W'(k % 4)) begin mismatched++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, res_id, k % 4); end
            compared++; if (res_data !== exp_data[k % 4]) begin mismatched++; $display("FAIL rr_data[%0d]: got %h want %h", k, res_data, exp_data[k % 4]); end
            compared++; if (req_ready !== want) begin mismatched++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, want); end
            if (k == 7) req_valid = 4'b0000;
            step();
            compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL rr_gap[%0d]: res_valid got %b want 0", k, res_valid); end
        end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rr_end_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_single_op();
        set_lane(2, 20'h40000, 20'h40000);
        req_valid = 4'b0100;
        res_ready = 1'b1;
        #1;
        compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        #1;
        compared++; if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin mismatched++; $display("FAIL single_mul: ready %b valid %b want 0000 0", req_ready, res_valid); end
        step();
        compared++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin mismatched++; $display("FAIL single_result: valid %b id %0d want 1 2", res_valid, res_id); end
        compared++; if (res_data !== 20'h7FFFF) begin mismatched++; $display("FAIL single_data: got %h want 7ffff", res_data); end
        step();
        compared++; if (res_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL single_done: valid %b busy %b want 0 0", res_valid, busy); end
    endtask

    task automatic test_backpressure();
        set_lane(0, 20'h08000, 20'h18000);
        set_lane(1, 20'h10000, 20'hF8000);
        req_valid = 4'b0001;
        res_ready = 1'b0;
        step();
        req_valid = 4'b0000;
        step();
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            #1;
            compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL bp_no_grant[%0d]: got %b want 0000", c, req_ready); end
            compared++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 20'h18000)
                begin mismatched++; $display("FAIL bp_stable[%0d]: valid %b id %0d data %h want 1 0 18000", c, res_valid, res_id, res_data); end
            step();
        end
        res_ready = 1'b1;
        #1;
        compared++; if (req_ready !== 4'b0010) begin mismatched++; $display("FAIL bp_release_grant: got %b want 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drop: res_valid got %b want 0", res_valid); end
        step();
        compared++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 20'hF0000)
            begin mismatched++; $display("FAIL bp_lane1: valid %b id %0d data %h want 1 1 f0000", res_valid, res_id, res_data); end
        step();
    endtask

    task automatic test_sign_cases();
        logic [BITSIZE-1:0] va [3];
        logic [BITSIZE-1:0] vb [3];
        logic [BITSIZE-1:0] ve [3];
        va[0] = 20'h7FFFF; vb[0] = 20'h10000; ve[0] = 20'h7FFFF;  // +max * 2.0 saturates high
        va[1] = 20'hFFFFF; vb[1] = 20'h40000; ve[1] = 20'hFFFF8;  // floor of -8 lsb
        va[2] = 20'hC0000; vb[2] = 20'hC0000; ve[2] = 20'h7FFFF;  // -8.0 squared saturates
        for (int v = 0; v < 3; v++) begin
            set_lane(3, va[v], vb[v]);
            req_valid = 4'b1000;
            res_ready = 1'b1;
            #1;
            compared++; if (req_ready !== 4'b1000) begin mismatched++; $display("FAIL sign_grant[%0d]: got %b want 1000", v, req_ready); end
            step();
            req_valid = 4'b0000;
            step();
            compared++; if (res_valid !== 1'b1 || res_id !== 2'd3) begin mismatched++; $display("FAIL sign_tag[%0d]: valid %b id %0d want 1 3", v, res_valid, res_id); end
            compared++; if (res_data !== ve[v]) begin mismatched++; $display("FAIL sign_data[%0d]: got %h want %h", v, res_data, ve[v]); end
            step();
        end
    endtask

    task automatic test_withdraw();
        int seen_lane1;
        seen_lane1 = 0;
        set_lane(0, 20'h04000, 20'h04000);
        set_lane(1, 20'h08000, 20'h08000);
        req_valid = 4'b0001;
        res_ready = 1'b0;
        step();
        req_valid = 4'b0000;
        step();
        compared++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 20'h02000)
            begin mismatched++; $display("FAIL wd_hold: valid %b id %0d data %h want 1 0 02000", res_valid, res_id, res_data); end
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL wd_no_grant[%0d]: got %b want 0000", c, req_ready); end
            step();
        end
        req_valid = 4'b0000;
        res_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (res_valid === 1'b1 && res_id === 2'd1) seen_lane1++;
        end
        compared++; if (seen_lane1 !== 0) begin mismatched++; $display("FAIL wd_no_result: lane1 results got %0d want 0", seen_lane1); end
        compared++; if (busy !== 1'b0 || res_valid !== 1'b0) begin mismatched++; $display("FAIL wd_idle: busy %b valid %b want 0 0", busy, res_valid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_op();
        test_backpressure();
        test_sign_cases();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
